// File: rtl/cla_seq_word_adder_pkg.sv
// Shared definitions for the nibble-serial CLA word adder.
//   state_t    : FSM states of the sequencer (IDLE, RUN)
//   NIBBLE_W   : width of one CLA slice
//   word_width : word width for a given number of slices
package cla_seq_word_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int word_width(input int nibbles);
        return NIBBLE_W * nibbles;
    endfunction

endpackage

// File: rtl/cla_seq_word_adder_cla4.sv
// 4-bit carry-lookahead adder slice.
// Ports:
//   a, b   : 4-bit operand nibbles
//   cin    : slice carry-in
//   s      : 4-bit sum nibble
//   c_msb  : carry into bit 3 (carry[2]), used for signed overflow
//   cout   : carry out of bit 3 (carry[3])
module cla_seq_word_adder_cla4 (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       c_msb,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] carry;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from generate/propagate terms.
    assign carry[0] = g[0] | (p[0] & cin);
    assign carry[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign carry[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);
    assign carry[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s     = p ^ {carry[2:0], cin};
    assign c_msb = carry[2];
    assign cout  = carry[3];

endmodule

// File: rtl/cla_seq_word_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that feeds one nibble per cycle
// through a single 4-bit CLA, registering the slice carry between nibbles.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while busy=0
//   sub        : 0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b, cin  : operands, captured on accepted start
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   sum, cout  : result and final carry (sub mode: 1 = no borrow)
//   overflow   : signed overflow of the full-width result
module cla_seq_word_adder
    import cla_seq_word_adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = word_width(NIBBLES),
    localparam int IDX_W   = $clog2(NIBBLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c_r;
    logic [IDX_W-1:0] idx;
    logic [3:0]       cla_s;
    logic             cla_c_msb;
    logic             cla_cout;
    logic             last;
    logic             accept;

    assign busy   = (state == RUN);
    assign last   = (idx == IDX_W'(NIBBLES - 1));
    assign accept = (state == IDLE) && start;

    cla_seq_word_adder_cla4 u_cla (
        .cin   (c_r),
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .s     (cla_s),
        .c_msb (cla_c_msb),
        .cout  (cla_cout)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control and visible result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            done  <= busy && last;
            if (busy && last) begin
                sum      <= {cla_s, s_sh[WIDTH-1:NIBBLE_W]};
                cout     <= cla_cout;
                overflow <= cla_cout ^ cla_c_msb;
            end
        end
    end

    // Operand/sum shifters and the inter-nibble carry. Subtraction is
    // a + ~b + 1, so the +1 rides in on the initial carry.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            c_r  <= sub ? 1'b1 : cin;
            idx  <= '0;
        end else if (busy) begin
            a_sh <= a_sh >> NIBBLE_W;
            b_sh <= b_sh >> NIBBLE_W;
            s_sh <= {cla_s, s_sh[WIDTH-1:NIBBLE_W]};
            c_r  <= cla_cout;
            idx  <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_cla_seq_word_adder.sv
module tb_cla_seq_word_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    cla_seq_word_adder #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    task automatic model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                         input logic rcin, input logic rsub,
                         output logic [W-1:0] es, output logic eco, output logic eov);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         c0;
        bb   = rsub ? ~rb : rb;
        c0   = rsub ? 1'b1 : rcin;
        full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, c0};
        es   = full[W-1:0];
        eco  = full[W];
        eov  = (ra[W-1] == bb[W-1]) && (es[W-1] != ra[W-1]);
    endtask

    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                          input logic lcin, input logic lsub);
        a     = la;
        b     = lb;
        cin   = lcin;
        sub   = lsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input string nm, input logic [W-1:0] es,
                             input logic eco, input logic eov);
        while (!done && (cyc - t0) < 20) tick();
        chk({nm, ".done"}, 32'(done), 32'd1);
        chk({nm, ".lat"}, 32'(cyc - t0), 32'(N));
        chk({nm, ".sum"}, 32'(sum), 32'(es));
        chk({nm, ".cout"}, 32'(cout), 32'(eco));
        chk({nm, ".ovf"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           seen;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen++;
        end
        chk("idle.nodone", 32'(seen), 32'd0);

        // Spec vectors.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'd1);
            wait_done($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
            tick();
            chk($sformatf("vec%0d.pulse", i), 32'(done), 32'd0);
        end

        // start during RUN with new operands is ignored.
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        a = 16'hABCD; b = 16'h9999; cin = 1'b1; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore", 16'h3333, 1'b0, 1'b0);

        // Back-to-back: start in the done cycle.
        launch(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.hold", 32'(sum), 32'h3333);
        wait_done("b2b", 16'h1011, 1'b0, 1'b0);

        // Reset in the 2nd RUN cycle abandons the operation.
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.sum", 32'(sum), 32'd0);
        chk("midrst.cout", 32'(cout), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) seen++;
        end
        chk("midrst.quiet", 32'(seen), 32'd0);

        // Reset and start together: reset wins.
        a = 16'h0001; b = 16'h0001; rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rststart.busy", 32'(busy), 32'd0);
        tick();
        chk("rststart.idle", 32'(busy), 32'd0);

        // Randomized operations against the arithmetic model, with inputs
        // scrambled while busy.
        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (i % 10 == 0) ra = 16'h7FFF + W'($urandom_range(0, 2));
            model(ra, rb, rc, rs, es, eco, eov);
            launch(ra, rb, rc, rs);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            wait_done($sformatf("rnd%0d", i), es, eco, eov);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
